// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive/transmit control slice:
//   - rx_state_e     : receive-controller FSM encoding (DATA / ESC_SEEN / APPLY)
//   - line_cfg_t     : packed line configuration held by the controller
//   - ESC_CODE_DEF   : default in-band escape byte
//   - CFG_*          : bit positions of the fields inside a config byte
//   - FRAME_LEN_*    : legal data-bits-per-frame bounds
//   - frame_len_legal: range check for a requested frame length
package uart_pkg;

    typedef enum logic [1:0] {
        ST_DATA     = 2'd0,
        ST_ESC_SEEN = 2'd1,
        ST_APPLY    = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [3:0] frame_length;
        logic       stop_bits;
        logic       parity_type;
        logic       parity;
    } line_cfg_t;

    localparam logic [7:0] ESC_CODE_DEF = 8'h1B;

    localparam int CFG_PARITY_BIT = 0;
    localparam int CFG_PTYPE_BIT  = 1;
    localparam int CFG_STOP_BIT   = 2;
    localparam int CFG_LEN_LSB    = 4;
    localparam int CFG_LEN_MSB    = 7;

    localparam logic [3:0] FRAME_LEN_MIN = 4'd5;
    localparam logic [3:0] FRAME_LEN_MAX = 4'd9;

    function automatic logic frame_len_legal(input logic [3:0] len);
        return (len >= FRAME_LEN_MIN) && (len <= FRAME_LEN_MAX);
    endfunction

endpackage

// File: rtl/uart_frame_fifo.sv
// uart_frame_fifo
// First-word-fall-through FIFO for UART frames, usable on RX and TX sides.
// Ports:
//   clk, rst          : clock and asynchronous active-high reset
//   push, push_data   : write request and data (ignored when full, unless
//                       a pop happens in the same cycle)
//   pop               : consume the head entry (ignored when empty)
//   pop_data          : head entry, forced to zero while empty
//   full, empty       : occupancy flags
module uart_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop_data = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state; a pop frees the slot a same-cycle push on a full FIFO reuses.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive-side controller between the UART frame receiver and the VGA
// command logic. Owns the receiver line configuration, decodes an in-band
// escape protocol (ESC + config byte, ESC + ESC = literal ESC) and buffers
// ordinary frames in a FWFT FIFO.
// Ports:
//   clk_16bd, rst               : 16x baud clock, async active-high reset
//   frame, frame_valid          : receiver output; accepted on frame_valid rise
//   parity, parity_type,
//   stop_bits, frame_length     : line configuration driven to the receiver
//   rd_en, rd_data, rd_valid    : FIFO consumer interface
//   overflow, cfg_error         : sticky error flags, cleared by clr_err
//   cfg_update                  : one-cycle pulse when a new config applies
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int         FIFO_DEPTH    = 4,
    parameter logic [7:0] ESC_CODE      = ESC_CODE_DEF,
    parameter int         ESC_TIMEOUT   = 384,
    parameter logic [3:0] DEF_FRAME_LEN = 4'd8
) (
    input  logic       clk_16bd,
    input  logic       rst,
    input  logic [8:0] frame,
    input  logic       frame_valid,
    output logic       parity,
    output logic       parity_type,
    output logic       stop_bits,
    output logic [3:0] frame_length,
    input  logic       rd_en,
    output logic [8:0] rd_data,
    output logic       rd_valid,
    output logic       overflow,
    output logic       cfg_error,
    input  logic       clr_err,
    output logic       cfg_update
);

    localparam int             TW       = $clog2(ESC_TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(ESC_TIMEOUT - 1);

    rx_state_e     state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    line_cfg_t     cfg_q, cfg_d;
    logic          fv_q, fv_d;
    logic          cfg_update_q, cfg_update_d;
    logic          overflow_q, overflow_d;
    logic          cfg_error_q, cfg_error_d;

    logic          fv_rise_s;
    logic          is_esc_s;
    logic          push_s;
    logic [8:0]    push_data_s;
    logic          cfg_err_set_s;
    logic          ovf_set_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;

    assign fv_rise_s = frame_valid & ~fv_q;
    // Bit 8 set means a 9-bit data frame, never an escape.
    assign is_esc_s  = ~frame[8] & (frame[7:0] == ESC_CODE);

    // Escape-protocol FSM: next state, pushes and config capture.
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        cfg_d         = cfg_q;
        cfg_update_d  = 1'b0;
        push_s        = 1'b0;
        push_data_s   = frame;
        cfg_err_set_s = 1'b0;
        case (state_q)
            // APPLY lasts one cycle; a frame landing in it is handled as in DATA.
            ST_DATA, ST_APPLY: begin
                state_d = ST_DATA;
                if (fv_rise_s) begin
                    if (is_esc_s) begin
                        state_d = ST_ESC_SEEN;
                        tmo_d   = {TW{1'b0}};
                    end else begin
                        push_s = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q;
                end
            end
            ST_ESC_SEEN: begin
                if (fv_rise_s) begin
                    tmo_d = {TW{1'b0}};
                    if (is_esc_s) begin
                        push_s      = 1'b1;
                        push_data_s = {1'b0, ESC_CODE};
                        state_d     = ST_DATA;
                    end else if (frame_len_legal(frame[CFG_LEN_MSB:CFG_LEN_LSB])) begin
                        cfg_d.parity       = frame[CFG_PARITY_BIT];
                        cfg_d.parity_type  = frame[CFG_PTYPE_BIT];
                        cfg_d.stop_bits    = frame[CFG_STOP_BIT];
                        cfg_d.frame_length = frame[CFG_LEN_MSB:CFG_LEN_LSB];
                        cfg_update_d       = 1'b1;
                        state_d            = ST_APPLY;
                    end else begin
                        cfg_err_set_s = 1'b1;
                        state_d       = ST_DATA;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Lone escape with nothing following: deliver it as data.
                    push_s      = 1'b1;
                    push_data_s = {1'b0, ESC_CODE};
                    tmo_d       = {TW{1'b0}};
                    state_d     = ST_DATA;
                end else begin
                    tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_DATA;
                tmo_d   = {TW{1'b0}};
            end
        endcase
    end

    // Sticky error flags; clr_err wins over a same-cycle set.
    always_comb begin
        fv_d      = frame_valid;
        ovf_set_s = push_s & fifo_full_s & ~rd_en;
        if (clr_err) begin
            overflow_d  = 1'b0;
            cfg_error_d = 1'b0;
        end else begin
            overflow_d  = overflow_q | ovf_set_s;
            cfg_error_d = cfg_error_q | cfg_err_set_s;
        end
    end

    // Control and configuration registers.
    always_ff @(posedge clk_16bd or posedge rst) begin
        if (rst) begin
            state_q      <= ST_DATA;
            tmo_q        <= {TW{1'b0}};
            cfg_q        <= {DEF_FRAME_LEN, 1'b0, 1'b0, 1'b0};
            fv_q         <= 1'b0;
            cfg_update_q <= 1'b0;
            overflow_q   <= 1'b0;
            cfg_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            cfg_q        <= cfg_d;
            fv_q         <= fv_d;
            cfg_update_q <= cfg_update_d;
            overflow_q   <= overflow_d;
            cfg_error_q  <= cfg_error_d;
        end
    end

    uart_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk_16bd),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign rd_valid     = ~fifo_empty_s;
    assign parity       = cfg_q.parity;
    assign parity_type  = cfg_q.parity_type;
    assign stop_bits    = cfg_q.stop_bits;
    assign frame_length = cfg_q.frame_length;
    assign overflow     = overflow_q;
    assign cfg_error    = cfg_error_q;
    assign cfg_update   = cfg_update_q;

endmodule
